// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 16-bit 5-stage core.
// Drives pipeline-register enables/flushes for load-use, branch, memory-wait and halt events.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [3:0]       IDEX_Rd,
  input  logic [3:0]       IFID_Rs,
  input  logic [3:0]       IFID_Rt,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             BranchTaken,
  input  logic             IMemReady,
  input  logic             EXMEM_MemAccess,
  input  logic             DMemReady,
  input  logic             HaltWB,
  output logic             PC_wen,
  output logic             IFID_wen,
  output logic             IFID_flush,
  output logic             IDEX_wen,
  output logic             IDEX_flush,
  output logic             EXMEM_wen,
  output logic             MEMWB_flush,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {StRun, StLoadStall, StMemWait, StHalted} state_e;

  // Bubbles still owed after the first one, loaded when a hazard is detected in RUN.
  localparam logic [1:0] BubbleInit = 2'(LOAD_BUBBLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic dmem_wait;

  assign load_use = IDEX_MemRead && (IDEX_Rd != 4'd0) &&
                    ((IFID_UsesRs && (IFID_Rs == IDEX_Rd)) ||
                     (IFID_UsesRt && (IFID_Rt == IDEX_Rd)));

  assign dmem_wait = EXMEM_MemAccess && !DMemReady;

  always_comb begin
    PC_wen      = 1'b1;
    IFID_wen    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_wen    = 1'b1;
    IDEX_flush  = 1'b0;
    EXMEM_wen   = 1'b1;
    MEMWB_flush = 1'b0;
    Halted      = 1'b0;
    state_d     = state_q;
    bcnt_d      = bcnt_q;

    if (state_q == StHalted) begin
      PC_wen    = 1'b0;
      IFID_wen  = 1'b0;
      IDEX_wen  = 1'b0;
      EXMEM_wen = 1'b0;
      Halted    = 1'b1;
    end else if (HaltWB) begin
      state_d = StHalted;
    end else if (dmem_wait) begin
      // Freeze everything up to MEM; WB receives a bubble while the access completes.
      PC_wen      = 1'b0;
      IFID_wen    = 1'b0;
      IDEX_wen    = 1'b0;
      EXMEM_wen   = 1'b0;
      MEMWB_flush = 1'b1;
      state_d     = StMemWait;
    end else if (state_q == StMemWait) begin
      state_d = (bcnt_q != 2'd0) ? StLoadStall : StRun;
    end else if ((state_q == StLoadStall) || load_use) begin
      PC_wen     = 1'b0;
      IFID_wen   = 1'b0;
      IDEX_flush = 1'b1;
      if (state_q == StLoadStall) begin
        bcnt_d = (bcnt_q != 2'd0) ? bcnt_q - 2'd1 : 2'd0;
      end else begin
        bcnt_d = BubbleInit;
      end
      state_d = (bcnt_d != 2'd0) ? StLoadStall : StRun;
    end else if (BranchTaken) begin
      IFID_flush = 1'b1;
    end else if (!IMemReady) begin
      PC_wen     = 1'b0;
      IFID_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_wen && (state_q != StHalted) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      bcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (1/2/3 bubbles, one with a narrow counter)
// checked every cycle against a rule-level model, plus directed literal scenarios.
module tb_hazard_stall_ctrl;

  localparam int NI = 3;
  // Output vector order: {PC_wen, IFID_wen, IFID_flush, IDEX_wen, IDEX_flush, EXMEM_wen,
  //                       MEMWB_flush, Halted}
  localparam logic [7:0] VRUN  = 8'b1101_0100;
  localparam logic [7:0] VBUB  = 8'b0001_1100;
  localparam logic [7:0] VMW   = 8'b0000_0010;
  localparam logic [7:0] VBR   = 8'b1111_0100;
  localparam logic [7:0] VIM   = 8'b0111_0100;
  localparam logic [7:0] VHALT = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, uses_rs, uses_rt, br, imem, mem_acc, dmem, halt_wb;
  logic [3:0] rd, rs, rt;

  logic [7:0]  vec [NI];
  logic [15:0] cnt [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LB = g + 1;
    localparam int unsigned CW = (g == 2) ? 4 : 16;
    logic          pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen;
    logic          memwb_flush, halted;
    logic [CW-1:0] sc;

    hazard_stall_ctrl #(.LOAD_BUBBLES(LB), .CNT_W(CW)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .IDEX_MemRead   (mem_read),
      .IDEX_Rd        (rd),
      .IFID_Rs        (rs),
      .IFID_Rt        (rt),
      .IFID_UsesRs    (uses_rs),
      .IFID_UsesRt    (uses_rt),
      .BranchTaken    (br),
      .IMemReady      (imem),
      .EXMEM_MemAccess(mem_acc),
      .DMemReady      (dmem),
      .HaltWB         (halt_wb),
      .PC_wen         (pc_wen),
      .IFID_wen       (ifid_wen),
      .IFID_flush     (ifid_flush),
      .IDEX_wen       (idex_wen),
      .IDEX_flush     (idex_flush),
      .EXMEM_wen      (exmem_wen),
      .MEMWB_flush    (memwb_flush),
      .Halted         (halted),
      .StallCount     (sc)
    );

    assign vec[g] = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
                     memwb_flush, halted};
    assign cnt[g] = 16'(sc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level model: halted flag, memory-wait flag, owed bubbles, stall cycles.
  bit         m_halt [NI];
  bit         m_wait [NI];
  int         m_left [NI];
  int         m_cnt  [NI];
  logic [7:0] ev;
  bit         hz;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_halt[k] = 0;
        m_wait[k] = 0;
        m_left[k] = 0;
        m_cnt[k]  = 0;
      end
    end else begin
      hz = mem_read && (rd != 0) && ((uses_rs && rs == rd) || (uses_rt && rt == rd));
      for (int k = 0; k < NI; k++) begin
        ev = VRUN;
        if (m_halt[k]) begin
          ev = VHALT;
        end else if (halt_wb) begin
          m_halt[k] = 1;
        end else if (mem_acc && !dmem) begin
          ev = VMW;
          m_wait[k] = 1;
        end else if (m_wait[k]) begin
          m_wait[k] = 0;
        end else if (m_left[k] > 0 || hz) begin
          ev = VBUB;
          m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : k;
        end else if (br) begin
          ev = VBR;
        end else if (!imem) begin
          ev = VIM;
        end
        chk($sformatf("model u%0d outputs", k), 32'(vec[k]), 32'(ev));
        chk($sformatf("model u%0d count", k), 32'(cnt[k]), m_cnt[k]);
        // Count uses the pre-edge halt state: the HaltWB cycle itself has PC_wen=1 anyway.
        if (ev != VHALT && !ev[7] && m_cnt[k] < ((k == 2) ? 15 : 65535)) m_cnt[k]++;
      end
    end
  end

  task automatic idle();
    mem_read = 0; rd = 0; rs = 0; rt = 0; uses_rs = 0; uses_rt = 0;
    br = 0; imem = 1; mem_acc = 0; dmem = 1; halt_wb = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    adv();
    adv();
    rst = 0;
  endtask

  task automatic lit(input string name, input int k, input logic [7:0] v, input int c);
    chk({name, " outputs"}, 32'(vec[k]), 32'(v));
    chk({name, " count"}, 32'(cnt[k]), c);
  endtask

  task automatic hazard_r3();
    idle();
    mem_read = 1; rd = 4'd3; rs = 4'd3; uses_rs = 1;
  endtask

  initial begin
    rst = 1;
    idle();
    adv();
    adv();
    rst = 0;

    // Reset state, idle RUN.
    @(negedge clk); lit("reset u1", 0, VRUN, 0); lit("reset u3", 2, VRUN, 0); adv();

    // Load-use with 1, 2, 3 bubbles.
    hazard_r3();
    @(negedge clk); lit("lu c1 u1", 0, VBUB, 0); lit("lu c1 u2", 1, VBUB, 0); adv();
    idle();
    @(negedge clk); lit("lu c2 u1", 0, VRUN, 1); lit("lu c2 u2", 1, VBUB, 1); adv();
    @(negedge clk); lit("lu c3 u2", 1, VRUN, 2); lit("lu c3 u3", 2, VBUB, 2); adv();
    @(negedge clk); lit("lu c4 u3", 2, VRUN, 3); adv();
    hazard_r3(); rd = 4'd0; rs = 4'd0;
    @(negedge clk); lit("lu r0 u1", 0, VRUN, 1); adv();

    // Load-use coincident with taken branch, then branch alone.
    do_reset();
    hazard_r3(); br = 1;
    @(negedge clk); lit("lu+br u1", 0, VBUB, 0); adv();
    idle(); br = 1;
    @(negedge clk); lit("br after lu u1", 0, VBR, 1); adv();

    // Data-memory wait of 4 cycles.
    do_reset();
    mem_acc = 1; dmem = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); lit($sformatf("dwait c%0d u1", i), 0, VMW, i); adv();
    end
    dmem = 1;
    @(negedge clk); lit("dwait done u1", 0, VRUN, 4); adv();

    // Data wait raised in LOAD_STALL (3 bubbles, one still owed afterwards).
    do_reset();
    hazard_r3();
    @(negedge clk); lit("ls c1 u3", 2, VBUB, 0); adv();
    idle();
    @(negedge clk); lit("ls c2 u3", 2, VBUB, 1); adv();
    mem_acc = 1; dmem = 0;
    @(negedge clk); lit("ls mw u3", 2, VMW, 2); adv();
    dmem = 1;
    @(negedge clk); lit("ls mw done u3", 2, VRUN, 3); adv();
    idle();
    @(negedge clk); lit("ls last bubble u3", 2, VBUB, 3); adv();
    @(negedge clk); lit("ls back run u3", 2, VRUN, 4); adv();

    // Reset mid-stall leaves no residual bubble.
    hazard_r3();
    @(negedge clk); lit("rst mid stall u3", 2, VBUB, 4); adv();
    do_reset();
    @(negedge clk); lit("after rst u3", 2, VRUN, 0); adv();

    // Fetch wait, and branch overriding it.
    do_reset();
    imem = 0;
    @(negedge clk); lit("imem wait u1", 0, VIM, 0); adv();
    br = 1;
    @(negedge clk); lit("imem+br u1", 0, VBR, 1); adv();

    // Halt freeze, then reset.
    idle(); halt_wb = 1;
    @(negedge clk); lit("haltwb u1", 0, VRUN, 1); adv();
    idle(); imem = 0;
    for (int i = 0; i < 10; i++) begin
      br = i[0];
      @(negedge clk); lit($sformatf("halted c%0d u1", i), 0, VHALT, 1); adv();
    end
    rst = 1; idle(); adv(); rst = 0;
    @(negedge clk); lit("rst from halt u1", 0, VRUN, 0); adv();

    // Random phase checked by the model process.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(99) < 3);
      mem_read = ($urandom_range(1) == 1);
      rd       = 4'($urandom_range(3));
      rs       = 4'($urandom_range(3));
      rt       = 4'($urandom_range(3));
      uses_rs  = ($urandom_range(1) == 1);
      uses_rt  = ($urandom_range(1) == 1);
      br       = ($urandom_range(4) == 0);
      imem     = ($urandom_range(4) != 0);
      mem_acc  = ($urandom_range(9) < 4);
      dmem     = ($urandom_range(9) < 6);
      halt_wb  = ($urandom_range(99) < 2);
      adv();
    end
    rst = 0;
    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
